// File: rtl/cam_pkg.sv
// Shared camera-path types: RGB332 pixel, source geometry defaults, and
// the frame-buffer writer state encoding.
package cam_pkg;

  localparam int unsigned SRC_W_DEF = 320;
  localparam int unsigned SRC_H_DEF = 240;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } fb_state_e;

endpackage

// File: rtl/window_counter.sv
// Source x/y position tracking with saturation, plus crop-window membership
// and last-window-pixel flags for the current position.
module window_counter #(
  parameter int unsigned SRC_W = 320,
  parameter int unsigned SRC_H = 240,
  parameter int unsigned X0    = 80,
  parameter int unsigned Y0    = 60,
  parameter int unsigned W     = 160,
  parameter int unsigned H     = 120
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic pix_valid_i,
  input  logic line_end_i,
  output logic in_win_c_o,
  output logic win_last_c_o
);

  localparam int unsigned XW = $clog2(SRC_W + 1);
  localparam int unsigned YW = $clog2(SRC_H + 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // A pixel coincident with line_end belongs to the old line, so only the
  // line advance has to be applied here.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (line_end_i) begin
        x_d = '0;
        if (y_q != YW'(SRC_H)) y_d = y_q + YW'(1);
      end else if (pix_valid_i && (x_q != XW'(SRC_W))) begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign in_win_c_o = (x_q >= XW'(X0)) && (x_q < XW'(X0 + W)) &&
                      (y_q >= YW'(Y0)) && (y_q < YW'(Y0 + H));
  assign win_last_c_o = (x_q == XW'(X0 + W - 1)) && (y_q == YW'(Y0 + H - 1));

endmodule

// File: rtl/rgb332_fb_writer.sv
// Crops a window from the RGB332 pixel stream and writes it into one of two
// frame RAM banks, always the bank the display reader is not scanning.
module rgb332_fb_writer
  import cam_pkg::*;
#(
  parameter int unsigned SRC_W  = SRC_W_DEF,
  parameter int unsigned SRC_H  = SRC_H_DEF,
  parameter int unsigned X0     = 80,
  parameter int unsigned Y0     = 60,
  parameter int unsigned W      = 160,
  parameter int unsigned H      = 120,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              line_end,
  input  logic              pix_valid,
  input  rgb332_t           pix_data,
  input  logic              rd_bank,
  output rgb332_t           data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              wr_bank,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(W * H);

  fb_state_e         state_q, state_d;
  rgb332_t           data_q, data_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d;
  logic              bank_q, bank_d;
  logic              done_q, done_d;

  logic sync_fall_c;
  logic write_c;
  logic in_win_c;
  logic win_last_c;

  assign sync_fall_c = (state_q == ST_SYNC) && !vsync;
  assign write_c     = (state_q == ST_ACTIVE) && !vsync && pix_valid && in_win_c;

  window_counter #(
    .SRC_W(SRC_W),
    .SRC_H(SRC_H),
    .X0   (X0),
    .Y0   (Y0),
    .W    (W),
    .H    (H)
  ) u_win (
    .clk_i       (pclk),
    .rst_i       (reset),
    .clr_i       (sync_fall_c),
    .en_i        ((state_q == ST_ACTIVE) && !vsync),
    .pix_valid_i (pix_valid),
    .line_end_i  (line_end),
    .in_win_c_o  (in_win_c),
    .win_last_c_o(win_last_c)
  );

  always_ff @(posedge pclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // vsync from any state other than SYNC aborts whatever was in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (vsync) state_d = ST_SYNC;
      ST_SYNC:   if (!vsync) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (vsync)                        state_d = ST_SYNC;
        else if (write_c && win_last_c)   state_d = ST_DONE;
      end
      ST_DONE:   if (vsync) state_d = ST_SYNC;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    waddr_d = waddr_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    if (sync_fall_c) begin
      bank_d = ~rd_bank;
      addr_d = bank_d ? BANK1_BASE : '0;
    end
    if (write_c) begin
      wren_d  = 1'b1;
      data_d  = pix_data;
      waddr_d = addr_q;
      addr_d  = addr_q + ADDR_W'(1);
      done_d  = win_last_c;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      data_q  <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      waddr_q <= waddr_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  assign data       = data_q;
  assign wraddress  = waddr_q;
  assign wren       = wren_q;
  assign wr_bank    = bank_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_rgb332_fb_writer.sv
// Directed bench for rgb332_fb_writer on a scaled-down geometry: a vector
// table for reset/start-up corners, then whole-frame sequences.
module tb_rgb332_fb_writer;

  localparam int SW = 16, SH = 12, X0 = 4, Y0 = 3, W = 8, H = 6, AW = 7;
  localparam int BASE1 = W * H;

  logic          pclk = 1'b0;
  logic          reset = 1'b1, vsync = 1'b0, line_end = 1'b0, pix_valid = 1'b0, rd_bank = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic [7:0]    data;
  logic [AW-1:0] wraddress;
  logic          wren, wr_bank, frame_done;

  int   checks = 0, failures = 0;
  int   n_wr, n_fd;
  int   h_a, h_d;
  logic h_bank;

  typedef struct {
    logic       rst, vs, le, pv;
    logic [7:0] pd;
    logic       rb;
    logic       ew;
    int         ea, ed;
    logic       efd, eb;
  } vec_t;
  vec_t tbl[$];

  rgb332_fb_writer #(
    .SRC_W(SW), .SRC_H(SH), .X0(X0), .Y0(Y0), .W(W), .H(H), .ADDR_W(AW)
  ) dut (
    .pclk      (pclk),
    .reset     (reset),
    .vsync     (vsync),
    .line_end  (line_end),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .rd_bank   (rd_bank),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .wr_bank   (wr_bank),
    .frame_done(frame_done)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, vs, le, pv, input logic [7:0] pd, input logic rb,
                      input logic ew, input int ea, input int ed, input logic efd, input logic eb);
    reset = rst; vsync = vs; line_end = le; pix_valid = pv; pix_data = pd; rd_bank = rb;
    @(posedge pclk);
    #1;
    if (wren)       n_wr++;
    if (frame_done) n_fd++;
    chk("wren", int'(wren), int'(ew));
    chk("wraddress", int'(wraddress), ea);
    chk("data", int'(data), ed);
    chk("frame_done", int'(frame_done), int'(efd));
    chk("wr_bank", int'(wr_bank), int'(eb));
  endtask

  function automatic void add(input logic rst, vs, le, pv, input logic [7:0] pd, input logic rb,
                              input logic ew, input int ea, input int ed, input logic efd,
                              input logic eb);
    vec_t v;
    v.rst = rst; v.vs = vs; v.le = le; v.pv = pv; v.pd = pd; v.rb = rb;
    v.ew = ew; v.ea = ea; v.ed = ed; v.efd = efd; v.eb = eb;
    tbl.push_back(v);
  endfunction

  // Full source frame; expected addresses come from window coordinates.
  task automatic run_frame(input logic rb, input logic rb_mid, input int npix, input bit gap,
                           input bit coinc, input int abort_y, input int seed);
    bit         done;
    int         base, exp_wr;
    logic       rdb, le, win, last;
    logic [7:0] pd;
    done = 0; n_wr = 0; n_fd = 0;
    repeat (2) step(0, 1, 0, 0, 8'h00, rb, 0, h_a, h_d, 0, h_bank);
    h_bank = ~rb;
    step(0, 0, 0, 0, 8'h00, rb, 0, h_a, h_d, 0, h_bank);
    base = h_bank ? BASE1 : 0;
    for (int y = 0; y < SH; y++) begin
      if (y == abort_y) break;
      rdb = (y >= 5) ? rb_mid : rb;
      for (int x = 0; x < npix; x++) begin
        if (gap) step(0, 0, 0, 0, 8'h00, rdb, 0, h_a, h_d, 0, h_bank);
        pd   = 8'(x * 29 + y * 7 + seed);
        le   = coinc && (x == npix - 1);
        win  = !done && x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H;
        last = win && x == X0 + W - 1 && y == Y0 + H - 1;
        if (win) begin
          h_a = base + (y - Y0) * W + (x - X0);
          h_d = int'(pd);
        end
        if (last) done = 1;
        step(0, 0, le, 1, pd, rdb, win, h_a, h_d, last, h_bank);
      end
      if (!coinc) step(0, 0, 1, 0, 8'h00, rdb, 0, h_a, h_d, 0, h_bank);
    end
    exp_wr = (abort_y < 0) ? W * H : (abort_y - Y0) * W;
    chk("write_count", n_wr, exp_wr);
    chk("frame_done_count", n_fd, (abort_y < 0) ? 1 : 0);
  endtask

  initial begin
    n_wr = 0; n_fd = 0;
    //  rst vs le pv pd     rb   ew ea  ed     fd bank
    add(1, 0, 0, 0, 8'h00, 0,   0, 0,  0,     0, 0);
    add(0, 1, 0, 0, 8'h00, 0,   0, 0,  0,     0, 0);
    add(0, 0, 0, 0, 8'h00, 0,   0, 0,  0,     0, 1);
    add(0, 0, 1, 0, 8'h00, 0,   0, 0,  0,     0, 1);
    add(0, 0, 1, 0, 8'h00, 0,   0, 0,  0,     0, 1);
    add(0, 0, 1, 0, 8'h00, 0,   0, 0,  0,     0, 1);
    add(0, 0, 0, 1, 8'h11, 0,   0, 0,  0,     0, 1);
    add(0, 0, 0, 1, 8'h22, 0,   0, 0,  0,     0, 1);
    add(0, 0, 0, 1, 8'h33, 0,   0, 0,  0,     0, 1);
    add(0, 0, 0, 1, 8'h44, 0,   0, 0,  0,     0, 1);
    add(0, 0, 0, 1, 8'hA5, 0,   1, 48, 8'hA5, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0,   0, 48, 8'hA5, 0, 1);
    add(0, 0, 0, 1, 8'h3C, 1,   1, 49, 8'h3C, 0, 1);
    add(1, 0, 0, 1, 8'h99, 0,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h77, 0,   0, 0,  0,     0, 0);
    add(0, 0, 1, 0, 8'h00, 0,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h66, 0,   0, 0,  0,     0, 0);
    add(0, 1, 0, 0, 8'h00, 0,   0, 0,  0,     0, 0);
    add(0, 0, 0, 0, 8'h00, 1,   0, 0,  0,     0, 0);
    add(0, 0, 1, 0, 8'h00, 1,   0, 0,  0,     0, 0);
    add(0, 0, 1, 0, 8'h00, 1,   0, 0,  0,     0, 0);
    add(0, 0, 1, 0, 8'h00, 1,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h01, 1,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h02, 1,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h03, 1,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'h04, 1,   0, 0,  0,     0, 0);
    add(0, 0, 0, 1, 8'hC3, 1,   1, 0,  8'hC3, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].vs, tbl[i].le, tbl[i].pv, tbl[i].pd, tbl[i].rb,
           tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].efd, tbl[i].eb);

    h_a = 0; h_d = 8'hC3; h_bank = 1'b0;

    run_frame(0, 0, SW,     0, 0, -1,     3);  // full frame into bank 1
    run_frame(1, 0, SW,     0, 0, -1,     17); // bank 0, rd_bank flips mid-frame
    run_frame(0, 0, SW + 2, 0, 0, -1,     41); // over-long lines
    run_frame(1, 1, X0 + W, 0, 1, -1,     59); // pixel coincident with line_end
    run_frame(1, 1, SW,     0, 0, Y0 + 4, 71); // aborted by vsync
    run_frame(0, 0, SW,     1, 0, -1,     88); // pix_valid every other cycle

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
